aes_128_inv: RTL and testbench
==============================

Name: aes_128_inv

Overview:
Iterative AES-128 inverse cipher (FIPS-197 decryption). It is the receive-side counterpart of the pipelined aes_128 encryptor and uses the same start/out_valid handshake. One 128-bit block at a time: a forward key expansion phase stores all 11 round keys, then one inverse round is applied per clock. It is area-optimised rather than pipelined and sits beside aes_128 in the AES core wrapper.

Parameters:
none (AES-128 only; Nk=4, Nr=10 fixed as constants in aes_pkg)

Ports:
clk        input   1    system clock, all logic on posedge
rst_n      input   1    synchronous active-low reset
start      input   1    rising edge requests a decryption
state      input   128  ciphertext, byte 0 in [127:120]
key        input   128  cipher key, byte 0 in [127:120]
out        output  128  plaintext, same byte order
out_valid  output  1    level; high while out holds a valid result

Behaviour:
- Reset (rst_n=0 at posedge): fsm=IDLE, out=0, out_valid=0, start_r=0, round counter=0, round-key file and data register cleared to 0.
- Reset applies in any state, including mid-operation; the in-flight result is discarded.
- Edge detect: start_r <= start each cycle; accept = start & ~start_r.
  - start already high on the first cycle after reset counts as an edge.
  - Holding start high never retriggers.
- Acceptance in IDLE or DONE only; accept in KEXP/ADD0/ROUND/FINAL is ignored.
- On accept: latch state into ct_r, key into rk[0], cnt=1, out_valid<=0, fsm->KEXP.
  - Inputs are sampled only at accept and may change afterwards.
- KEXP (10 cycles, cnt 1..10): rk[cnt] <= expand(rk[cnt-1], rcon[cnt]).
  - rcon = 01,02,04,08,10,20,40,80,1b,36.
  - expand: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - After cnt=10: fsm->ADD0.
- ADD0 (1 cycle): s <= ct_r ^ rk[10]; cnt<=9; fsm->ROUND.
- ROUND (9 cycles, cnt 9..1): s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[cnt]); cnt decrements.
  - After cnt=1: fsm->FINAL.
- FINAL (1 cycle): out <= InvSubBytes(InvShiftRows(s)) ^ rk[0]; out_valid<=1; fsm->DONE.
- DONE: out and out_valid held until the next accept.
  - An accept in DONE drops out_valid on the following edge; out keeps its old value until FINAL overwrites it.
- Latency: accept sampled at edge E0; out_valid first seen high after edge E0+21 (10 KEXP + 1 ADD0 + 9 ROUND + 1 FINAL). This matches the encryptor's 21-cycle budget.
- Arithmetic rules:
  - GF(2^8) polynomial 0x11b.
  - InvMixColumns coefficients 0e,0b,0d,09.
  - InvShiftRows rotates row r right by r bytes.
  - Column-major state: column c = bits [127-32c -: 32].
- No backpressure: the consumer must capture out while out_valid is high or before issuing a new start.

Decomposition:
- aes_pkg holds:
  - constants NR=10, NK=4;
  - rcon table;
  - functions sbox(byte), inv_sbox(byte), xtime, gmul(byte,coef);
  - fsm enum {IDLE,KEXP,ADD0,ROUND,FINAL,DONE}.
- One combinational sub-module, aes_inv_round: inputs s, rk, is_final; output next_s. Applies InvShiftRows, InvSubBytes and AddRoundKey, then InvMixColumns unless is_final. Instantiated once.
- Key expansion stays inline using aes_pkg::sbox on 4 bytes.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, state 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> out=00112233445566778899aabbccddeeff, out_valid rising exactly 21 cycles after accept.
- FIPS-197 App B: key 2b7e151628aed2a6abf7158809cf4f3c, state 3925841d02dc09fbdc118597196a0b32 -> out=3243f6a8885a308d313198a2e0370734; internal rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Zero key, state 66e94bd4ef8a2c3b884cfa59ca342b2e -> out=0; change state/key to random values 3 cycles after accept -> result unchanged.
- start held high 40 cycles, plus a second rising edge at cycle 10 -> exactly one operation; out_valid at cycle 21; the mid-run edge is ignored.
- rst_n low at cycle 12 of a run -> next edge out=0, out_valid=0, fsm IDLE; a fresh start then produces the correct C.1 result.
- Back-to-back: accept in DONE with the App B vector after the C.1 result -> out_valid low one cycle later, high again 21 cycles after the second accept with the App B plaintext; scoreboard against the aes_128 encryptor loopback for 1000 random key/plaintext pairs.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the inverse cipher.
// The S-boxes are computed (field inverse plus affine map) rather than tabulated.
package aes_pkg;

   localparam int NR = 10;
   localparam int NK = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KEXP  = 3'd1,
      ADD0  = 3'd2,
      ROUND = 3'd3,
      FINAL = 3'd4,
      DONE  = 3'd5
   } fsm_t;

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] coef);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (coef[i]) p = p ^ x;
         else         p = p;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gmul(a, a);
      acc = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gmul(sq, sq);
         acc = gmul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] inv_mix_coef(input int k);
      case (k)
         0:       inv_mix_coef = 8'h0e;
         1:       inv_mix_coef = 8'h0b;
         2:       inv_mix_coef = 8'h0d;
         3:       inv_mix_coef = 8'h09;
         default: inv_mix_coef = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] s,
   input  logic [127:0] rk,
   input  logic         is_final,
   output logic [127:0] next_s
);

   logic [127:0] sub_s;
   logic [127:0] mix_s;

   // Byte (r,c) comes from column (c-r) mod 4 of the same row, then the key is added
   always_comb begin
      sub_s = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sub_s[127-32*c-8*r -: 8] = inv_sbox(s[127-32*((c-r+4)%4)-8*r -: 8]);
         end
      end
      sub_s = sub_s ^ rk;
   end

   // Row r of the circulant {0e,0b,0d,09} matrix uses coefficient (j-r) mod 4 for byte j
   always_comb begin
      mix_s = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
               mix_s[127-32*c-8*r -: 8] = mix_s[127-32*c-8*r -: 8] ^
                  gmul(sub_s[127-32*c-8*j -: 8], inv_mix_coef((j-r+4)%4));
            end
         end
      end
   end

   // The last round skips InvMixColumns
   always_comb begin
      if (is_final) next_s = sub_s;
      else          next_s = mix_s;
   end

endmodule

// File: rtl/aes_128_inv.sv
// Iterative AES-128 decryptor: expands and stores all round keys first, then
// applies one inverse round per clock; 21 cycles from accepted start to out_valid.
module aes_128_inv
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] state,
   input  logic [127:0] key,
   output logic [127:0] out,
   output logic         out_valid
);

   fsm_t         fsm_r;
   logic         start_r;
   logic [3:0]   cnt_r;
   logic [127:0] ct_r;
   logic [127:0] s_r;
   logic [127:0] rk_r [0:NR];

   logic         accept_s;
   logic [127:0] prev_rk_s;
   logic [31:0]  t_s;
   logic [127:0] exp_rk_s;
   logic [127:0] next_s;
   logic         is_final_s;

   assign accept_s   = start & ~start_r;
   assign is_final_s = (fsm_r == FINAL);

   // Forward key schedule step producing rk[cnt] from rk[cnt-1]
   always_comb begin
      prev_rk_s = rk_r[cnt_r - 4'd1];
      t_s = {sbox(prev_rk_s[23:16]), sbox(prev_rk_s[15:8]),
             sbox(prev_rk_s[7:0]),   sbox(prev_rk_s[31:24])} ^ {rcon(cnt_r), 24'h0};
      exp_rk_s[127:96] = prev_rk_s[127:96] ^ t_s;
      exp_rk_s[95:64]  = prev_rk_s[95:64]  ^ exp_rk_s[127:96];
      exp_rk_s[63:32]  = prev_rk_s[63:32]  ^ exp_rk_s[95:64];
      exp_rk_s[31:0]   = prev_rk_s[31:0]   ^ exp_rk_s[63:32];
   end

   // In FINAL cnt_r has reached 0, so the same key select yields rk[0]
   aes_inv_round u_round (
      .s        (s_r),
      .rk       (rk_r[cnt_r]),
      .is_final (is_final_s),
      .next_s   (next_s)
   );

   // Control FSM, round-key file and data path registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_r     <= IDLE;
         start_r   <= 1'b0;
         cnt_r     <= 4'd0;
         ct_r      <= 128'h0;
         s_r       <= 128'h0;
         out       <= 128'h0;
         out_valid <= 1'b0;
         for (int i = 0; i <= NR; i++) rk_r[i] <= 128'h0;
      end else begin
         start_r <= start;
         case (fsm_r)
            IDLE, DONE: begin
               if (accept_s) begin
                  ct_r      <= state;
                  rk_r[0]   <= key;
                  cnt_r     <= 4'd1;
                  out_valid <= 1'b0;
                  fsm_r     <= KEXP;
               end
            end
            KEXP: begin
               rk_r[cnt_r] <= exp_rk_s;
               if (cnt_r == 4'(NR)) fsm_r <= ADD0;
               else                 cnt_r <= cnt_r + 4'd1;
            end
            ADD0: begin
               s_r   <= ct_r ^ rk_r[NR];
               cnt_r <= 4'(NR - 1);
               fsm_r <= ROUND;
            end
            ROUND: begin
               s_r   <= next_s;
               cnt_r <= cnt_r - 4'd1;
               if (cnt_r == 4'd1) fsm_r <= FINAL;
            end
            FINAL: begin
               out       <= next_s;
               out_valid <= 1'b1;
               fsm_r     <= DONE;
            end
            default: fsm_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_128_inv.sv
// Self-checking bench for aes_128_inv: forward-cipher reference model plus a
// cycle timing model compared against out/out_valid on every cycle.
`timescale 1ns/1ps
module tb_aes_128_inv;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] tb_state;
   logic [127:0] tb_key;
   logic [127:0] out;
   logic         out_valid;

   int checks   = 0;
   int failures = 0;

   logic [7:0]   sbox_tbl [256];
   logic [127:0] exp_pt;
   logic         cmp_en = 1'b0;

   // timing model state
   logic         m_prev;
   logic         m_busy;
   int           m_cd;
   logic         m_valid;
   logic [127:0] m_out;
   logic [127:0] m_pt;

   aes_128_inv dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .state     (tb_state),
      .key       (tb_key),
      .out       (out),
      .out_valid (out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %032h expected %032h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] mul2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box by walking generator 3 and its inverse around the multiplicative group
   task automatic build_sbox();
      logic [7:0] p;
      logic [7:0] q;
      p = 8'h01;
      q = 8'h01;
      for (int i = 0; i < 255; i++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         sbox_tbl[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      end
      sbox_tbl[0] = 8'h63;
   endtask

   // Forward AES-128 encryption; the decryptor must invert it
   function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
      logic [31:0]  w [44];
      logic [7:0]   st [16];
      logic [7:0]   tmp [16];
      logic [31:0]  t;
      logic [31:0]  kw;
      logic [7:0]   rc;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]], sbox_tbl[t[31:24]]} ^ {rc, 24'h0};
            rc = mul2(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int b = 0; b < 16; b++) begin
         kw = w[b/4];
         st[b] = pt[127-8*b -: 8] ^ kw[31-8*(b%4) -: 8];
      end
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int b = 0; b < 16; b++) st[b] = sbox_tbl[st[b]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               tmp[4*c+r] = st[4*((c+r)%4)+r];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               if (rnd < 10)
                  st[4*c+r] = mul2(tmp[4*c+r]) ^ mul2(tmp[4*c+(r+1)%4]) ^ tmp[4*c+(r+1)%4]
                              ^ tmp[4*c+(r+2)%4] ^ tmp[4*c+(r+3)%4];
               else
                  st[4*c+r] = tmp[4*c+r];
         for (int b = 0; b < 16; b++) begin
            kw = w[4*rnd + b/4];
            st[b] = st[b] ^ kw[31-8*(b%4) -: 8];
         end
      end
      for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
      return res;
   endfunction

   // Timing model: accept on a rising start when idle, result visible 21 edges later
   always @(posedge clk) begin
      if (!rst_n) begin
         m_prev  <= 1'b0;
         m_busy  <= 1'b0;
         m_cd    <= 0;
         m_valid <= 1'b0;
         m_out   <= 128'h0;
      end else begin
         m_prev <= start;
         if (m_busy) begin
            if (m_cd == 0) begin
               m_busy  <= 1'b0;
               m_valid <= 1'b1;
               m_out   <= m_pt;
            end else begin
               m_cd <= m_cd - 1;
            end
         end else if (start && !m_prev) begin
            m_busy  <= 1'b1;
            m_cd    <= 20;
            m_valid <= 1'b0;
            m_pt    <= exp_pt;
         end
      end
   end

   // Per-cycle comparison against the timing model
   always @(negedge clk) begin
      if (cmp_en) begin
         check_int("cycle out_valid", int'(out_valid), int'(m_valid));
         check128("cycle out", out, m_out);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start with a vector; optionally scramble the inputs change_at cycles after accept
   task automatic run_vec(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt,
                          input string name, input int change_at);
      int n;
      tb_state = ct;
      tb_key   = k;
      exp_pt   = pt;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check_int({name, " valid drop"}, int'(out_valid), 0);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
         if (n == change_at) begin
            tb_state = {$urandom, $urandom, $urandom, $urandom};
            tb_key   = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      check_int({name, " latency"}, n, 21);
      check128({name, " out"}, out, pt);
   endtask

   initial begin
      int first;
      logic [127:0] r_pt;
      logic [127:0] r_key;

      build_sbox();
      rst_n    = 1'b0;
      start    = 1'b0;
      tb_state = 128'h0;
      tb_key   = 128'h0;
      exp_pt   = 128'h0;
      tick();
      tick();
      cmp_en = 1'b1;
      check128("reset out", out, 128'h0);
      check_int("reset out_valid", int'(out_valid), 0);
      rst_n = 1'b1;

      check_int("model sbox 00", int'(sbox_tbl[8'h00]), 32'h63);
      check_int("model sbox 53", int'(sbox_tbl[8'h53]), 32'hed);
      check128("model enc C1", model_encrypt(C1_PT, C1_KEY), C1_CT);
      check128("model enc B", model_encrypt(B_PT, B_KEY), B_CT);
      check128("model enc zero", model_encrypt(128'h0, 128'h0), Z_CT);

      tick();
      run_vec(C1_CT, C1_KEY, C1_PT, "C1", -1);
      tick();

      // back-to-back from DONE: out must hold the previous plaintext until FINAL
      tb_state = B_CT;
      tb_key   = B_KEY;
      exp_pt   = B_PT;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check128("b2b out hold", out, C1_PT);
      check_int("b2b valid drop", int'(out_valid), 0);
      first = 0;
      while (!out_valid && first < 40) begin
         tick();
         first++;
      end
      check_int("appB latency", first, 21);
      check128("appB out", out, B_PT);
      check128("appB rk10", dut.rk_r[10], B_RK10);

      run_vec(Z_CT, 128'h0, 128'h0, "zero key change", 3);
      tick();

      // start held high with a second rising edge mid-run
      tb_state = C1_CT;
      tb_key   = C1_KEY;
      exp_pt   = C1_PT;
      start    = 1'b1;
      tick();
      first = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         start = (cyc != 10);
         tick();
         if (out_valid && first < 0) first = cyc;
      end
      start = 1'b0;
      check_int("held start latency", first, 21);
      check128("held start out", out, C1_PT);
      check_int("held start valid", int'(out_valid), 1);
      tick();

      // reset in the middle of a run
      run_vec_abort();
      check128("midrst out", out, 128'h0);
      check_int("midrst out_valid", int'(out_valid), 0);
      check_int("midrst fsm", int'(dut.fsm_r), int'(aes_pkg::IDLE));
      tb_state = C1_CT;
      tb_key   = C1_KEY;
      exp_pt   = C1_PT;
      start    = 1'b1;
      tick();
      rst_n = 1'b1;
      run_vec(C1_CT, C1_KEY, C1_PT, "after reset", -1);
      tick();

      for (int i = 0; i < 1000; i++) begin
         r_pt  = {$urandom, $urandom, $urandom, $urandom};
         r_key = {$urandom, $urandom, $urandom, $urandom};
         run_vec(model_encrypt(r_pt, r_key), r_key, r_pt, "random", -1);
      end
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Start an App B run and pull rst_n low on its twelfth cycle; rst_n stays low on return
   task automatic run_vec_abort();
      tb_state = B_CT;
      tb_key   = B_KEY;
      exp_pt   = B_PT;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      rst_n = 1'b0;
      tick();
   endtask

endmodule
